// File: rtl/gpio_in_filter_pkg.sv
// Shared defaults, edge classification and the counter-width helper for the GPIO input filter.
package gpio_in_filter_pkg;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// CPU-facing bundle of the GPIO input filter: pin levels and enables in, debounced data and flags out.
interface gpio_in_filter_if
  import gpio_in_filter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] gpio_pin;
  logic [WIDTH-1:0] gpio_oen;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_clear;
  logic [WIDTH-1:0] gpio_data_in;
  logic [WIDTH-1:0] irq_pending;
  logic             irq;

  modport master (
    output gpio_pin, gpio_oen, rise_en, fall_en, irq_clear,
    input  gpio_data_in, irq_pending, irq
  );

  modport slave (
    input  gpio_pin, gpio_oen, rise_en, fall_en, irq_clear,
    output gpio_data_in, irq_pending, irq
  );

endinterface

// File: rtl/gpio_in_filter_bit.sv
// One GPIO input bit: synchroniser, debounce counter, accepted level and edge-qualified pending flag.
module gpio_in_bit
  import gpio_in_filter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  input  logic oen_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic clear_i,
  output logic level_o,
  output logic pending_o
);

  localparam int                 CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pending_q, pending_d;
  logic                   sync_lvl;
  edge_e                  edge_kind;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pin_i};
    sync_lvl  = sync_q[SYNC_STAGES-1];
    cnt_d     = '0;
    level_d   = level_q;
    edge_kind = EDGE_NONE;

    // Accept on the cycle the count would hit DEBOUNCE_CYCLES, so the counter never needs that value.
    if (sync_lvl != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync_lvl;
        edge_kind = sync_lvl ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    pending_d = pending_q & ~clear_i;
    if (!oen_i && ((edge_kind == EDGE_RISE && rise_en_i) ||
                   (edge_kind == EDGE_FALL && fall_en_i))) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = level_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input filter top: WIDTH independent filtered bits plus the combined interrupt request.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input logic             clk,
  input logic             rst,
  gpio_in_filter_if.slave bus
);

  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] pending_w;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    gpio_in_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .pin_i     (bus.gpio_pin[b]),
      .oen_i     (bus.gpio_oen[b]),
      .rise_en_i (bus.rise_en[b]),
      .fall_en_i (bus.fall_en[b]),
      .clear_i   (bus.irq_clear[b]),
      .level_o   (level_w[b]),
      .pending_o (pending_w[b])
    );
  end

  // irq is derived only from the pending flops so it never glitches on raw input activity.
  assign bus.gpio_data_in = level_w;
  assign bus.irq_pending  = pending_w;
  assign bus.irq          = |pending_w;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4): vector table plus corner sequences.
module tb_gpio_in_filter;

  logic clk;
  logic rstR;
  logic [7:0] pinR, oenR, riseR, fallR, clrR;
  int checks;
  int failures;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] pin;
    logic [7:0] clr;
    logic [7:0] expData;
    logic [7:0] expPend;
  } vec_t;

  vec_t vecs[$];

  gpio_in_filter_if #(.WIDTH(8)) bus ();

  gpio_in_filter #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rstR),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic rst, input logic [7:0] pin,
                        input logic [7:0] clr, input logic [7:0] expData,
                        input logic [7:0] expPend, input int count);
    vec_t v;
    v.name    = name;
    v.rst     = rst;
    v.pin     = pin;
    v.clr     = clr;
    v.expData = expData;
    v.expPend = expPend;
    for (int i = 0; i < count; i++) vecs.push_back(v);
  endtask

  // Drive the current input registers, then advance one rising edge and settle.
  task automatic applyStimulus();
    bus.gpio_pin  = pinR;
    bus.gpio_oen  = oenR;
    bus.rise_en   = riseR;
    bus.fall_en   = fallR;
    bus.irq_clear = clrR;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expData, input logic [7:0] expPend);
    logic expIrq;
    expIrq = |expPend;
    checks++;
    if (bus.gpio_data_in !== expData) begin
      failures++;
      $display("[TB] FAIL %s gpio_data_in: actual=%02h expected=%02h", name, bus.gpio_data_in, expData);
    end
    checks++;
    if (bus.irq_pending !== expPend) begin
      failures++;
      $display("[TB] FAIL %s irq_pending: actual=%02h expected=%02h", name, bus.irq_pending, expPend);
    end
    checks++;
    if (bus.irq !== expIrq) begin
      failures++;
      $display("[TB] FAIL %s irq: actual=%0b expected=%0b", name, bus.irq, expIrq);
    end
  endtask

  task automatic holdCheck(input int n, input string name, input logic [7:0] expData, input logic [7:0] expPend);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      checkOutput(name, expData, expPend);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstR  = 1'b1;
    pinR  = 8'h00;
    oenR  = 8'h00;
    riseR = 8'hFF;
    fallR = 8'hFF;
    clrR  = 8'h00;

    // Reset, first rising event with clear, rejected short pulse on bit 1, then accepted step on bit 1.
    addVec("reset_hold",     1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    addVec("reset_release",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    addVec("rise0_wait",     1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 5);
    addVec("rise0_accept",   1'b0, 8'h01, 8'h00, 8'h01, 8'h01, 2);
    addVec("rise0_clear",    1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    addVec("rise0_idle",     1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 1);
    addVec("glitch1_high",   1'b0, 8'h03, 8'h00, 8'h01, 8'h00, 3);
    addVec("glitch1_low",    1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 4);
    addVec("rise1_wait",     1'b0, 8'h03, 8'h00, 8'h01, 8'h00, 5);
    addVec("rise1_accept",   1'b0, 8'h03, 8'h00, 8'h03, 8'h02, 1);
    addVec("rise1_clear",    1'b0, 8'h03, 8'h02, 8'h03, 8'h00, 1);

    foreach (vecs[i]) begin
      rstR = vecs[i].rst;
      pinR = vecs[i].pin;
      clrR = vecs[i].clr;
      applyStimulus();
      checkOutput(vecs[i].name, vecs[i].expData, vecs[i].expPend);
    end
    clrR = 8'h00;

    // Falling event on bit 0, then a rising event landing together with a clear: set must win.
    pinR = 8'h02;
    holdCheck(5, "fall0_wait",   8'h03, 8'h00);
    holdCheck(1, "fall0_accept", 8'h02, 8'h01);
    pinR = 8'h03;
    holdCheck(5, "rise0b_wait",  8'h02, 8'h01);
    clrR = 8'h01;
    holdCheck(1, "set_wins",     8'h03, 8'h01);
    holdCheck(1, "clear0",       8'h03, 8'h00);
    holdCheck(1, "clear0_noop",  8'h03, 8'h00);
    clrR = 8'h00;

    // Output-enabled bit 2 follows the pin but raises nothing, including when oen is dropped.
    oenR = 8'h04;
    pinR = 8'h07;
    holdCheck(5, "oen_rise_wait",   8'h03, 8'h00);
    holdCheck(5, "oen_rise_follow", 8'h07, 8'h00);
    pinR = 8'h03;
    holdCheck(5, "oen_fall_wait",   8'h07, 8'h00);
    holdCheck(5, "oen_fall_follow", 8'h03, 8'h00);
    oenR = 8'h00;
    holdCheck(3, "oen_toggle",      8'h03, 8'h00);

    // Bit 3 with only the falling enable, then reset in the middle of a later rise.
    riseR = 8'hF7;
    pinR  = 8'h0B;
    holdCheck(5, "rise3_masked_wait", 8'h03, 8'h00);
    holdCheck(3, "rise3_masked",      8'h0B, 8'h00);
    pinR  = 8'h03;
    holdCheck(5, "fall3_wait",        8'h0B, 8'h00);
    holdCheck(1, "fall3_accept",      8'h03, 8'h08);
    clrR  = 8'h08;
    holdCheck(1, "fall3_clear",       8'h03, 8'h00);
    clrR  = 8'h00;
    riseR = 8'hFF;
    pinR  = 8'h0B;
    holdCheck(3, "mid_debounce",      8'h03, 8'h00);
    rstR  = 1'b1;
    holdCheck(1, "reset_mid",         8'h00, 8'h00);
    rstR  = 1'b0;
    holdCheck(5, "post_reset_wait",   8'h00, 8'h00);
    holdCheck(1, "post_reset_rise",   8'h0B, 8'h0B);
    clrR  = 8'h0B;
    holdCheck(1, "post_reset_clear",  8'h0B, 8'h00);
    clrR  = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
